// File: rtl/uart_pkg.sv
// Shared UART-side definitions: serializer FSM encodings, NUL constant, length clamp.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [7:0] ASCII_NUL = 8'h00;

  // Requested length limited to the number of character slots (2**addr_space_exp).
  function automatic int clamp_len(input int len, input int addr_space_exp);
    int depth;
    depth = 1 << addr_space_exp;
    return (len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/wide_word_serializer_if.sv
// Load and character-stream handshake bundle for the wide word serializer.
// Latency: n/a (wiring only).
// Backpressure: load_ready / out_ready carry the flow control of each direction.
interface wide_word_serializer_if #(
  parameter int DATA_SIZE      = 8,
  parameter int ADDR_SPACE_EXP = 6
);
  localparam int DEPTH = 2**ADDR_SPACE_EXP;

  logic                          load_valid;
  logic                          load_ready;
  logic [DATA_SIZE*DEPTH-1:0]    load_data;
  logic [ADDR_SPACE_EXP:0]       load_len;
  logic                          flush;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_SIZE-1:0]          out_data;
  logic                          busy;
  logic                          done;

  // Producer of messages and consumer of characters.
  modport master (
    output load_valid, load_data, load_len, flush, out_ready,
    input  load_ready, out_valid, out_data, busy, done
  );

  // The serializer itself.
  modport slave (
    input  load_valid, load_data, load_len, flush, out_ready,
    output load_ready, out_valid, out_data, busy, done
  );

endinterface

// File: rtl/wide_word_serializer.sv
// Captures DEPTH characters in one load and streams them out one per valid/ready transfer.
// Latency: first character valid the cycle after load acceptance; one character per transfer.
// Backpressure: out_data/out_valid hold while out_ready is low; load_ready low while sending or flushing.
// Build option: TRIM_NUL_EN ends a message early at the first NUL character.
module wide_word_serializer
  import uart_pkg::*;
#(
  parameter int DATA_SIZE      = 8,
  parameter int ADDR_SPACE_EXP = 6
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  wide_word_serializer_if.slave bus
);

  localparam int DEPTH = 2**ADDR_SPACE_EXP;
  localparam int W     = DATA_SIZE*DEPTH;
  localparam int LEN_W = ADDR_SPACE_EXP+1;

  localparam logic [ADDR_SPACE_EXP-1:0] PTR_ONE = 1;
  localparam logic [LEN_W-1:0]          LEN_ONE = 1;
  localparam logic [DATA_SIZE-1:0]      NUL_CHR = DATA_SIZE'(ASCII_NUL);

  logic [0:0]                state_q, state_d;
  logic [ADDR_SPACE_EXP-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic                      done_q, done_d;
  logic [DATA_SIZE-1:0]      mem_q [DEPTH];
  logic [DATA_SIZE-1:0]      mem_d [DEPTH];

  logic                      load_fire;
  logic                      xfer_fire;
  logic                      last_xfer;
  logic                      load_empty;
  logic [ADDR_SPACE_EXP-1:0] rd_ptr_nxt;
  logic [LEN_W-1:0]          load_len_c;

  assign bus.load_ready = (state_q == ST_IDLE) & ~bus.flush;
  assign bus.out_valid  = (state_q == ST_SEND);
  assign bus.busy       = (state_q == ST_SEND);
  assign bus.done       = done_q;
  assign bus.out_data   = mem_q[rd_ptr_q];

  assign load_fire  = bus.load_valid & bus.load_ready;
  assign xfer_fire  = bus.out_valid & bus.out_ready;
  assign rd_ptr_nxt = rd_ptr_q + PTR_ONE;
  assign load_len_c = LEN_W'(clamp_len(32'(bus.load_len), ADDR_SPACE_EXP));

`ifdef TRIM_NUL_EN
  // A NUL in slot 0 means there is nothing to send; a NUL ahead of the pointer ends the message.
  assign load_empty = (load_len_c == '0) || (bus.load_data[W-1 -: DATA_SIZE] == NUL_CHR);
  assign last_xfer  = (({1'b0, rd_ptr_q} + LEN_ONE) == len_q) || (mem_q[rd_ptr_nxt] == NUL_CHR);
`else
  // Only the programmed length ends a message; NULs are ordinary characters.
  assign load_empty = (load_len_c == '0);
  assign last_xfer  = (({1'b0, rd_ptr_q} + LEN_ONE) == len_q);
`endif

  // Next-state: flush beats load and transfer; storage changes only on an accepted load.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    len_d    = len_q;
    done_d   = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      mem_d[k] = mem_q[k];
    end

    if (bus.flush) begin
      state_d  = ST_IDLE;
      rd_ptr_d = '0;
    end else if (load_fire) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_d[k] = bus.load_data[W-1-k*DATA_SIZE -: DATA_SIZE];
      end
      rd_ptr_d = '0;
      if (load_empty) begin
        len_d  = '0;
        done_d = 1'b1;
      end else begin
        len_d   = load_len_c;
        state_d = ST_SEND;
      end
    end else if (xfer_fire) begin
      // Pointer may wrap to 0 after a full-depth message; harmless since we return to IDLE.
      rd_ptr_d = rd_ptr_nxt;
      if (last_xfer) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  // State, pointer, length, done pulse and character storage registers.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rd_ptr_q <= '0;
      len_q    <= '0;
      done_q   <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      len_q    <= len_d;
      done_q   <= done_d;
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= mem_d[k];
      end
    end
  end

endmodule
